pc_fetch_controller: RTL and testbench

Multi-cycle sequencer that drives the program-counter datapath and the instruction-memory fetch handshake. It decides, once per instruction, when the PC register is written and which next-PC source is selected. The source is one of PC+4, PC+4+(imm<<2), or reg1+(imm<<2). It sits between the decoder/hazard logic and the PC block, and it also provides a retired-instruction counter, a memory-timeout watchdog and halt handling.

---
 rtl/pc_fetch_controller.sv | 137 +++++++++++++
 tb/tb_pc_fetch_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_controller.sv
// Per-instruction sequencer for the PC datapath and the instruction-fetch handshake.
// It also keeps a retired-instruction counter, a fetch-timeout watchdog and a sticky halt/fault.
module pc_fetch_controller #(
  parameter int DBITS    = 32,
  parameter int TIMEOUT  = 15,
  parameter int CNT_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             imemAck,
  input  logic             isBranch,
  input  logic             isJump,
  input  logic             isHalt,
  input  logic             cmp,
  input  logic             stall,
  output logic             imemReq,
  output logic             irWrtEn,
  output logic             pcWrtEn,
  output logic [1:0]       pcSel,
  output logic [DBITS-1:0] retired,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [1:0] SEL_PC4 = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_REG = 2'd2;

  localparam logic [CNT_BITS-1:0] TO_VAL = CNT_BITS'(TIMEOUT);
  localparam logic                TO_EN  = (TIMEOUT != 0);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_BITS-1:0] r_wdog;
  logic [CNT_BITS-1:0] w_wdog_inc;
  logic                w_wdog_clr;
  logic                w_wdog_step;
  logic                w_retire;
  logic [DBITS-1:0]    r_retired;

  assign w_wdog_inc = r_wdog + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_wdog_clr  = 1'b0;
    w_wdog_step = 1'b0;
    w_retire    = 1'b0;
    imemReq     = 1'b0;
    irWrtEn     = 1'b0;
    pcWrtEn     = 1'b0;
    pcSel       = SEL_PC4;
    halted      = 1'b0;
    fault       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        imemReq    = 1'b1;
        w_wdog_clr = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        imemReq = 1'b1;
        // A late ack still beats the watchdog in the same cycle.
        if (imemAck) begin
          irWrtEn = 1'b1;
          w_next  = S_DECODE;
        end else begin
          w_wdog_step = 1'b1;
          if (TO_EN && (w_wdog_inc == TO_VAL)) w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        if (isHalt) begin
          w_retire = 1'b1;
          w_next   = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pcWrtEn  = 1'b1;
          w_retire = 1'b1;
          w_next   = S_FETCH;
          if (isJump)               pcSel = SEL_REG;
          else if (isBranch && cmp) pcSel = SEL_BR;
          else                      pcSel = SEL_PC4;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= '0;
    end else if (w_wdog_clr) begin
      r_wdog <= '0;
    end else if (w_wdog_step) begin
      r_wdog <= w_wdog_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 1'b1;
  end

  assign retired = r_retired;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: a vector table of instructions plus
// hand-written reset, wrap, halt and watchdog sequences.
module tb_pc_fetch_controller;

  logic        clk, reset, start, imemAck, isBranch, isJump, isHalt, cmp, stall;
  logic        imemReq, irWrtEn, pcWrtEn, halted, fault;
  logic [1:0]  pcSel;
  logic [31:0] retired;

  logic        rst2, start2, ack2;
  logic        imemReq2, irWrtEn2, pcWrtEn2, halted2, fault2;
  logic [1:0]  pcSel2;
  logic [31:0] retired2;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] exp_ret;

  pc_fetch_controller #(.DBITS(32), .TIMEOUT(4), .CNT_BITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .imemAck(imemAck),
    .isBranch(isBranch), .isJump(isJump), .isHalt(isHalt), .cmp(cmp), .stall(stall),
    .imemReq(imemReq), .irWrtEn(irWrtEn), .pcWrtEn(pcWrtEn), .pcSel(pcSel),
    .retired(retired), .halted(halted), .fault(fault)
  );

  pc_fetch_controller #(.DBITS(32), .TIMEOUT(0), .CNT_BITS(4)) dut_nowd (
    .clk(clk), .reset(rst2), .start(start2), .imemAck(ack2),
    .isBranch(isBranch), .isJump(isJump), .isHalt(isHalt), .cmp(cmp), .stall(stall),
    .imemReq(imemReq2), .irWrtEn(irWrtEn2), .pcWrtEn(pcWrtEn2), .pcSel(pcSel2),
    .retired(retired2), .halted(halted2), .fault(fault2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the edge into FETCH; leaves one step after the edge
  // into the next state (FETCH, or HALT for a halt instruction).
  task automatic do_instr(input int lat, input logic br, input logic jp, input logic c,
                          input logic hlt, input int stalls, input logic [1:0] esel);
    int t0;
    t0 = cyc;
    imemAck = 0; isBranch = 0; isJump = 0; isHalt = 0; cmp = 0; stall = 0;
    #1;
    chk1("fetch_req", imemReq, 1'b1);
    chk1("fetch_pcwe", pcWrtEn, 1'b0);
    tick();
    for (int i = 1; i <= lat; i++) begin
      imemAck = (i == lat);
      #1;
      chk1("wait_req", imemReq, 1'b1);
      chk1("wait_irwe", irWrtEn, (i == lat));
      chk1("wait_fault", fault, 1'b0);
      tick();
    end
    imemAck = 0; isBranch = br; isJump = jp; isHalt = hlt;
    #1;
    chk1("dec_req", imemReq, 1'b0);
    chk1("dec_irwe", irWrtEn, 1'b0);
    chk1("dec_pcwe", pcWrtEn, 1'b0);
    tick();
    isHalt = 0;
    if (hlt) begin
      exp_ret = exp_ret + 1;
      #1;
      chk1("halt_flag", halted, 1'b1);
      chk1("halt_pcwe", pcWrtEn, 1'b0);
      chkw("halt_retired", retired, exp_ret);
      return;
    end
    cmp = c;
    for (int s = 0; s < stalls; s++) begin
      stall = 1;
      #1;
      chk1("stall_pcwe", pcWrtEn, 1'b0);
      chkw("stall_pcsel", 32'(pcSel), 32'd0);
      chkw("stall_retired", retired, exp_ret);
      tick();
    end
    stall = 0;
    #1;
    chk1("exec_pcwe", pcWrtEn, 1'b1);
    chkw("exec_pcsel", 32'(pcSel), 32'(esel));
    chkw("exec_latency", 32'(cyc - t0), 32'(2 + lat + stalls));
    tick();
    exp_ret = exp_ret + 1;
    isBranch = 0; isJump = 0; cmp = 0;
    #1;
    chk1("next_fetch_req", imemReq, 1'b1);
    chkw("retired", retired, exp_ret);
  endtask

  typedef struct {
    int         lat;
    logic       br;
    logic       jp;
    logic       c;
    int         stalls;
    logic [1:0] esel;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int bad;
    vecs[0] = '{lat: 1, br: 0, jp: 0, c: 0, stalls: 0, esel: 2'd0};  // plain
    vecs[1] = '{lat: 1, br: 1, jp: 0, c: 1, stalls: 0, esel: 2'd1};  // taken branch
    vecs[2] = '{lat: 1, br: 1, jp: 0, c: 0, stalls: 0, esel: 2'd0};  // not taken
    vecs[3] = '{lat: 1, br: 0, jp: 1, c: 0, stalls: 0, esel: 2'd2};  // jump
    vecs[4] = '{lat: 1, br: 1, jp: 1, c: 1, stalls: 0, esel: 2'd2};  // jump wins
    vecs[5] = '{lat: 2, br: 0, jp: 1, c: 1, stalls: 3, esel: 2'd2};  // stalled jump
    vecs[6] = '{lat: 4, br: 1, jp: 0, c: 1, stalls: 0, esel: 2'd1};  // ack at expiry

    reset = 0; start = 0; imemAck = 0; isBranch = 0; isJump = 0; isHalt = 0;
    cmp = 0; stall = 0; rst2 = 0; start2 = 0; ack2 = 0;
    exp_ret = 0;
    #3;
    chk1("rst_req", imemReq, 1'b0);
    chk1("rst_pcwe", pcWrtEn, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chkw("rst_retired", retired, 32'd0);
    tick();
    reset = 1;
    tick();
    #1;
    chk1("idle_req", imemReq, 1'b0);

    // Instruction table, back to back after a single start.
    start = 1;
    tick();
    start = 0;
    for (int v = 0; v < 7; v++)
      do_instr(vecs[v].lat, vecs[v].br, vecs[v].jp, vecs[v].c, 1'b0, vecs[v].stalls, vecs[v].esel);

    // Asynchronous reset in the middle of an acked WAIT cycle.
    tick();
    imemAck = 1;
    #1;
    chk1("mid_irwe_pre", irWrtEn, 1'b1);
    reset = 0;
    #1;
    chk1("mid_req_rst", imemReq, 1'b0);
    chk1("mid_irwe_rst", irWrtEn, 1'b0);
    chkw("mid_retired_rst", retired, 32'd0);
    exp_ret = 0;
    imemAck = 0;
    tick();
    reset = 1;
    tick();
    tick();
    chk1("post_rst_idle", imemReq, 1'b0);

    // Counter wrap from all-ones.
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    exp_ret = 32'hFFFF_FFFF;
    start = 1;
    tick();
    start = 0;
    do_instr(1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'd0);
    chkw("wrap_zero", retired, 32'd0);

    // Halt, then start must be ignored.
    do_instr(1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2'd0);
    start = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("halt_hold", halted, 1'b1);
      chk1("halt_req", imemReq, 1'b0);
      chkw("halt_ret_hold", retired, exp_ret);
    end
    start = 0;
    reset = 0;
    #1;
    chk1("halt_rst", halted, 1'b0);
    tick();
    reset = 1;
    exp_ret = 0;

    // Watchdog expiry after the 4th WAIT cycle without ack.
    start = 1;
    tick();
    start = 0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk1("wd_wait_req", imemReq, 1'b1);
      chk1("wd_wait_fault", fault, 1'b0);
      tick();
    end
    chk1("wd_fault", fault, 1'b1);
    chk1("wd_req_off", imemReq, 1'b0);
    start = 1;
    tick();
    tick();
    chk1("wd_fault_hold", fault, 1'b1);
    chk1("wd_req_hold", imemReq, 1'b0);
    start = 0;
    reset = 0;
    #1;
    chk1("wd_rst", fault, 1'b0);

    // Watchdog disabled: 100 WAIT cycles, never faults.
    rst2 = 1;
    start2 = 1;
    tick();
    start2 = 0;
    tick();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (fault2 !== 1'b0 || imemReq2 !== 1'b1) bad++;
      tick();
    end
    chkw("nowd_bad_cycles", 32'(bad), 32'd0);
    chk1("nowd_fault", fault2, 1'b0);
    chk1("nowd_req", imemReq2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
